study_guide: RTL and testbench

- Parametrised successor of the single-song study mode in the keyboard-trainer datapath.
- Steps through any song from the song ROM one note at a time and lights the target key.
- Waits for the player's hit, grades it, then replays the correct note on the tone generator.
- Keeps per-song hit/miss/timeout statistics, with a bounded retry count and a per-note timeout.
- Sits between the key/octave front end (hit decoder), the song ROM and the sound engine.

---
 rtl/study_guide_pkg.sv | 31 +++
 rtl/study_guide_timer.sv | 25 ++
 rtl/study_guide.sv | 249 ++++++++++++++++++++++++
 tb/tb_study_guide.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/study_guide_pkg.sv
// Shared types, default widths and helpers for the study-mode guide and its timer.
package study_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHOW     = 3'd1,
        ST_WAIT     = 3'd2,
        ST_GRADE    = 3'd3,
        ST_RETRY    = 3'd4,
        ST_PLAY     = 3'd5,
        ST_PLAYWAIT = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    localparam int unsigned NOTE_REST     = 0;
    localparam int          NOTE_W_DEF    = 3;
    localparam int          OCT_W_DEF     = 3;
    localparam int          LEN_W_DEF     = 3;
    localparam int          NOTE_KEYS_DEF = 7;
    localparam int          MAX_KEYS      = 32;

    // Wide result so callers with any key count can slice what they need.
    function automatic logic [MAX_KEYS-1:0] note_to_onehot(input logic [7:0] note, input int keys);
        logic [MAX_KEYS-1:0] oh;
        oh = '0;
        if (note != 8'(NOTE_REST) && int'(note) <= keys)
            oh = MAX_KEYS'(1) << (note - 8'd1);
        return oh;
    endfunction

endpackage

// File: rtl/study_guide_timer.sv
// Per-attempt timeout down-counter: clear reloads, enable counts, expire pulses on terminal count.
module study_timer #(
    parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= CW'(TIMEOUT_CYC - 1);
        else if (enable && count != '0)
            count <= count - CW'(1);
    end

    assign expire = enable && (count == '0);

endmodule

// File: rtl/study_guide.sv
// Study-mode guide: walks a song step by step, grades player hits, replays the correct tone.
// Build option STUDY_GUIDE_OCTAVE_CHECK_EN makes grading also require the octave to match.
//
// state    | meaning
// IDLE     | mode inactive, waiting for start
// SHOW     | latch goal note from song ROM
// WAIT     | target key lit, waiting for hit or timeout
// GRADE    | compare latched hit against goal
// RETRY    | wait for feedback tone, then retry or force advance
// PLAY     | request the correct tone
// PLAYWAIT | wait for the tone to finish, then next step or DONE
// DONE     | song finished
module study_guide
    import study_pkg::*;
#(
    parameter int          NOTE_KEYS   = NOTE_KEYS_DEF,
    parameter int          NOTE_W      = NOTE_W_DEF,
    parameter int          OCT_W       = OCT_W_DEF,
    parameter int          LEN_W       = LEN_W_DEF,
    parameter int          IDX_W       = 6,
    parameter int          MAX_TRY     = 3,
    parameter int unsigned TIMEOUT_CYC = 100_000_000,
    parameter int          STAT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic                 hit_valid,
    input  logic [OCT_W-1:0]     hit_octave,
    input  logic [NOTE_W-1:0]    hit_note,
    output logic [IDX_W-1:0]     step_idx,
    input  logic [OCT_W-1:0]     goal_octave,
    input  logic [NOTE_W-1:0]    goal_note,
    input  logic [LEN_W-1:0]     goal_length,
    input  logic [IDX_W-1:0]     last_idx,
    output logic                 snd_req,
    output logic [OCT_W-1:0]     snd_octave,
    output logic [NOTE_W-1:0]    snd_note,
    output logic [LEN_W-1:0]     snd_length,
    input  logic                 snd_busy,
    output logic [NOTE_KEYS-1:0] note_led,
    output logic [STAT_W-1:0]    hit_cnt,
    output logic [STAT_W-1:0]    miss_cnt,
    output logic [STAT_W-1:0]    tout_cnt,
    output logic                 done,
    output logic [2:0]           state
);

    state_t              state_q, state_nxt;
    logic [OCT_W-1:0]    goal_oct_q, hit_oct_q;
    logic [NOTE_W-1:0]   goal_note_q, hit_note_q;
    logic [LEN_W-1:0]    goal_len_q;
    logic [2:0]          try_q;
    logic [1:0]          pw_cnt_q;
    logic                busy_seen_q;
    logic                timer_expire, match, try_last, pw_finish;

    logic step_clr, step_inc, latch_goal, hit_latch, try_inc, led_clr;
    logic stats_clr, inc_hit, inc_miss, inc_tout, fb_req, play_req;

    study_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != ST_WAIT),
        .enable (state_q == ST_WAIT),
        .expire (timer_expire)
    );

`ifdef STUDY_GUIDE_OCTAVE_CHECK_EN
    assign match = (hit_note_q == goal_note_q) && (hit_oct_q == goal_oct_q);
`else
    assign match = (hit_note_q == goal_note_q);
`endif

    assign try_last = ({1'b0, try_q} + 4'd1) == 4'(MAX_TRY);
    // A tone that never raises busy within four cycles is treated as already finished.
    assign pw_finish = busy_seen_q ? !snd_busy : (!snd_busy && pw_cnt_q == 2'd3);

    always_comb begin
        state_nxt  = state_q;
        step_clr   = 1'b0;
        step_inc   = 1'b0;
        latch_goal = 1'b0;
        hit_latch  = 1'b0;
        try_inc    = 1'b0;
        led_clr    = 1'b0;
        stats_clr  = 1'b0;
        inc_hit    = 1'b0;
        inc_miss   = 1'b0;
        inc_tout   = 1'b0;
        fb_req     = 1'b0;
        play_req   = 1'b0;
        if (!en) begin
            state_nxt = ST_IDLE;
            step_clr  = 1'b1;
            led_clr   = 1'b1;
        end else if (start) begin
            state_nxt = ST_SHOW;
            step_clr  = 1'b1;
            stats_clr = 1'b1;
            led_clr   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_SHOW: begin
                    latch_goal = 1'b1;
                    state_nxt  = ST_WAIT;
                end
                ST_WAIT: begin
                    if (goal_note_q == NOTE_W'(NOTE_REST)) begin
                        state_nxt = ST_PLAY;
                    end else if (hit_valid) begin
                        hit_latch = 1'b1;
                        state_nxt = ST_GRADE;
                    end else if (timer_expire) begin
                        inc_tout  = 1'b1;
                        state_nxt = ST_RETRY;
                    end
                end
                ST_GRADE: begin
                    if (match) begin
                        inc_hit   = 1'b1;
                        state_nxt = ST_PLAY;
                    end else begin
                        inc_miss  = 1'b1;
                        fb_req    = 1'b1;
                        state_nxt = ST_RETRY;
                    end
                end
                ST_RETRY: begin
                    // snd_req still high means the engine has not yet had a chance to raise busy.
                    if (!snd_busy && !snd_req) begin
                        if (try_last) begin
                            state_nxt = ST_PLAY;
                        end else begin
                            try_inc   = 1'b1;
                            state_nxt = ST_WAIT;
                        end
                    end
                end
                ST_PLAY: begin
                    play_req  = 1'b1;
                    state_nxt = ST_PLAYWAIT;
                end
                ST_PLAYWAIT: begin
                    if (pw_finish) begin
                        if (step_idx >= last_idx) begin
                            led_clr   = 1'b1;
                            state_nxt = ST_DONE;
                        end else begin
                            step_inc  = 1'b1;
                            state_nxt = ST_SHOW;
                        end
                    end
                end
                ST_DONE: ;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_idx    <= '0;
            goal_oct_q  <= '0;
            goal_note_q <= '0;
            goal_len_q  <= '0;
            hit_oct_q   <= '0;
            hit_note_q  <= '0;
            try_q       <= '0;
            pw_cnt_q    <= '0;
            busy_seen_q <= 1'b0;
            note_led    <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            tout_cnt    <= '0;
            snd_req     <= 1'b0;
            snd_octave  <= '0;
            snd_note    <= '0;
            snd_length  <= '0;
        end else begin
            state_q <= state_nxt;
            snd_req <= fb_req | play_req;

            if (step_clr)
                step_idx <= '0;
            else if (step_inc)
                step_idx <= step_idx + IDX_W'(1);

            if (latch_goal) begin
                goal_oct_q  <= goal_octave;
                goal_note_q <= goal_note;
                goal_len_q  <= goal_length;
                try_q       <= '0;
            end else if (try_inc) begin
                try_q <= try_q + 3'd1;
            end

            if (hit_latch) begin
                hit_oct_q  <= hit_octave;
                hit_note_q <= hit_note;
            end

            if (led_clr)
                note_led <= '0;
            else if (latch_goal)
                note_led <= NOTE_KEYS'(note_to_onehot(8'(goal_note), NOTE_KEYS));

            if (stats_clr) begin
                hit_cnt  <= '0;
                miss_cnt <= '0;
                tout_cnt <= '0;
            end else begin
                if (inc_hit && hit_cnt != '1)
                    hit_cnt <= hit_cnt + STAT_W'(1);
                if (inc_miss && miss_cnt != '1)
                    miss_cnt <= miss_cnt + STAT_W'(1);
                if (inc_tout && tout_cnt != '1)
                    tout_cnt <= tout_cnt + STAT_W'(1);
            end

            if (fb_req) begin
                snd_octave <= hit_oct_q;
                snd_note   <= hit_note_q;
                snd_length <= goal_len_q;
            end else if (play_req) begin
                snd_octave <= goal_oct_q;
                snd_note   <= goal_note_q;
                snd_length <= goal_len_q;
            end

            if (play_req) begin
                pw_cnt_q    <= '0;
                busy_seen_q <= 1'b0;
            end else if (state_q == ST_PLAYWAIT) begin
                if (snd_busy)
                    busy_seen_q <= 1'b1;
                if (pw_cnt_q != 2'd3)
                    pw_cnt_q <= pw_cnt_q + 2'd1;
            end
        end
    end

    assign done  = (state_q == ST_DONE);
    assign state = state_q;

endmodule

// File: tb/tb_study_guide.sv
// Scoreboard bench for study_guide: expected tones queued by stimulus, checked by a snd_req monitor.
module tb_study_guide;

    logic       clk = 1'b0;
    logic       rst, en, start, hit_valid;
    logic [2:0] hit_octave, hit_note;
    logic [5:0] step_idx, last_idx;
    logic [2:0] goal_octave, goal_note, goal_length;
    logic       snd_req, snd_busy, done;
    logic [2:0] snd_octave, snd_note, snd_length, state;
    logic [6:0] note_led;
    logic [7:0] hit_cnt, miss_cnt, tout_cnt;

    logic [2:0] rom_oct [64];
    logic [2:0] rom_note[64];
    logic [2:0] rom_len [64];

    int         checks = 0;
    int         errors = 0;
    int         busy_cnt = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_t;

    always #5 clk = ~clk;

    assign goal_octave = rom_oct[step_idx];
    assign goal_note   = rom_note[step_idx];
    assign goal_length = rom_len[step_idx];

    study_guide #(.TIMEOUT_CYC(20)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .hit_valid(hit_valid), .hit_octave(hit_octave), .hit_note(hit_note),
        .step_idx(step_idx), .goal_octave(goal_octave), .goal_note(goal_note),
        .goal_length(goal_length), .last_idx(last_idx),
        .snd_req(snd_req), .snd_octave(snd_octave), .snd_note(snd_note),
        .snd_length(snd_length), .snd_busy(snd_busy), .note_led(note_led),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .tout_cnt(tout_cnt),
        .done(done), .state(state)
    );

    // Sound engine: busy for 10 cycles after each request.
    always @(negedge clk) begin
        if (snd_req === 1'b1) busy_cnt = 10;
        if (busy_cnt > 0) begin
            snd_busy = 1'b1;
            busy_cnt--;
        end else begin
            snd_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (snd_req === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tone_unexpected: got o=%0d n=%0d l=%0d, none expected",
                         snd_octave, snd_note, snd_length);
            end else begin
                mon_t = exp_q.pop_front();
                if ({snd_octave, snd_note, snd_length} !== mon_t) begin
                    errors++;
                    $display("FAIL tone: got o=%0d n=%0d l=%0d expected o=%0d n=%0d l=%0d",
                             snd_octave, snd_note, snd_length, mon_t[8:6], mon_t[5:3], mon_t[2:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_tone(input int o, input int n, input int l);
        exp_q.push_back({o[2:0], n[2:0], l[2:0]});
    endtask

    task automatic set_step(input int i, input int o, input int n, input int l);
        rom_oct[i]  = o[2:0];
        rom_note[i] = n[2:0];
        rom_len[i]  = l[2:0];
    endtask

    task automatic wait_state(input int s, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(posedge clk); #1;
            if (int'(state) == s) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: timed out in state %0d waiting for %0d", name, state, s);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_hit(input int o, input int n);
        hit_valid  = 1'b1;
        hit_octave = o[2:0];
        hit_note   = n[2:0];
        @(posedge clk); #1;
        hit_valid  = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 64; i++) set_step(i, 0, 0, 0);
        rst = 1'b1; en = 1'b1; start = 1'b0; hit_valid = 1'b0;
        hit_octave = '0; hit_note = '0; last_idx = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_step", step_idx, 0);
        check("rst_led", note_led, 0);
        check("rst_done", done, 0);
        check("rst_hit", hit_cnt, 0);
        check("rst_snd_note", snd_note, 0);
        rst = 1'b0;

        // Three correct hits through a three-step song.
        set_step(0, 4, 1, 2); set_step(1, 4, 3, 3); set_step(2, 4, 5, 4); last_idx = 6'd2;
        push_tone(4, 1, 2); push_tone(4, 3, 3); push_tone(4, 5, 4);
        pulse_start();
        wait_state(2, "t1_wait0"); check("t1_led0", note_led, 7'b0000001); pulse_hit(4, 1);
        wait_state(2, "t1_wait1"); check("t1_led1", note_led, 7'b0000100); pulse_hit(4, 3);
        wait_state(2, "t1_wait2"); check("t1_led2", note_led, 7'b0010000); pulse_hit(4, 5);
        wait_state(7, "t1_done");
        check("t1_done", done, 1);
        check("t1_hit", hit_cnt, 3);
        check("t1_miss", miss_cnt, 0);
        check("t1_step", step_idx, 2);
        check("t1_led_done", note_led, 0);

        // Three wrong hits force advance with the correct tone.
        set_step(0, 4, 2, 1); set_step(1, 4, 6, 1); last_idx = 6'd1;
        push_tone(4, 4, 1); push_tone(4, 4, 1); push_tone(4, 4, 1); push_tone(4, 2, 1);
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            wait_state(2, "t2_wait");
            pulse_hit(4, 4);
        end
        wait_state(1, "t2_show");
        check("t2_step", step_idx, 1);
        check("t2_miss", miss_cnt, 3);
        check("t2_hit", hit_cnt, 0);

        // Mid-song restart, then three timeouts.
        set_step(0, 2, 1, 5); set_step(1, 2, 7, 5); last_idx = 6'd1;
        push_tone(2, 1, 5);
        pulse_start();
        check("t3_restart_state", state, 1);
        check("t3_restart_step", step_idx, 0);
        check("t3_restart_miss", miss_cnt, 0);
        wait_state(2, "t3_wait");
        n = 0;
        for (int i = 1; i <= 100 && n == 0; i++) begin
            @(posedge clk); #1;
            if (tout_cnt == 8'd1) n = i;
        end
        check("t3_tout_latency", n, 20);
        wait_state(1, "t3_show");
        check("t3_tout", tout_cnt, 3);
        check("t3_hit", hit_cnt, 0);
        check("t3_step", step_idx, 1);

        // Rest step plays immediately without grading.
        set_step(0, 3, 0, 2); set_step(1, 3, 3, 2); last_idx = 6'd1;
        push_tone(3, 0, 2); push_tone(3, 3, 2);
        pulse_start();
        wait_state(2, "t4_wait_rest");
        check("t4_led_rest", note_led, 0);
        wait_state(1, "t4_show");
        check("t4_hit", hit_cnt, 0);
        check("t4_miss", miss_cnt, 0);
        check("t4_tout", tout_cnt, 0);
        check("t4_step", step_idx, 1);
        wait_state(2, "t4_wait1");
        pulse_hit(3, 3);
        wait_state(7, "t4_done");
        check("t4_hit_end", hit_cnt, 1);

        // Right note, wrong octave, on a one-step song.
        set_step(0, 4, 3, 1); last_idx = 6'd0;
`ifdef STUDY_GUIDE_OCTAVE_CHECK_EN
        push_tone(5, 3, 1);
`endif
        push_tone(4, 3, 1);
        pulse_start();
        wait_state(2, "t5_wait");
        pulse_hit(5, 3);
`ifdef STUDY_GUIDE_OCTAVE_CHECK_EN
        wait_state(2, "t5_retry_wait");
        check("t5_miss_oct", miss_cnt, 1);
        check("t5_hit_oct", hit_cnt, 0);
        pulse_hit(4, 3);
`endif
        wait_state(7, "t5_done");
        check("t5_hit", hit_cnt, 1);
`ifdef STUDY_GUIDE_OCTAVE_CHECK_EN
        check("t5_miss", miss_cnt, 1);
`else
        check("t5_miss", miss_cnt, 0);
`endif
        check("t5_step", step_idx, 0);

        // en low holds statistics; reset during PLAYWAIT clears everything.
        set_step(0, 4, 1, 2); set_step(1, 4, 3, 3); set_step(2, 4, 5, 4); last_idx = 6'd2;
        push_tone(4, 1, 2);
        pulse_start();
        wait_state(2, "t6_wait0"); pulse_hit(4, 1);
        wait_state(2, "t6_wait1");
        check("t6_step1", step_idx, 1);
        en = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        check("t6_en_state", state, 0);
        check("t6_en_step", step_idx, 0);
        check("t6_en_led", note_led, 0);
        check("t6_en_hit", hit_cnt, 1);
        check("t6_en_snd_note", snd_note, 1);
        push_tone(4, 1, 2);
        pulse_start();
        wait_state(2, "t6_wait2"); pulse_hit(4, 1);
        wait_state(6, "t6_playwait");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_rst_state", state, 0);
        check("t6_rst_hit", hit_cnt, 0);
        check("t6_rst_led", note_led, 0);
        check("t6_rst_snd_req", snd_req, 0);
        check("t6_rst_snd_note", snd_note, 0);
        check("t6_rst_snd_oct", snd_octave, 0);
        check("t6_rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        check("tones_outstanding", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
